irom_fetch_ctrl: RTL and testbench

Read sequencer for the 64×8 image ROM. On a start request it drives the ROM's active-low chip enable and address to fetch a window of pixels, starting at a given address and wrapping modulo 64. It absorbs the ROM's one-cycle read latency with a small FIFO and streams the pixels downstream over a valid/ready handshake. It sits between the image ROM and the pixel-processing datapath and is the only block that drives the ROM.

---
 rtl/irom_pkg.sv | 14 +
 rtl/irom_fetch_fifo.sv | 61 ++++++
 rtl/irom_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_irom_fetch_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irom_pkg.sv
// Shared constants and FSM state type for the image-ROM read sequencer.
package irom_pkg;

    localparam int IROM_ADDR_W = 6;
    localparam int IROM_DATA_W = 8;
    localparam int IMG_DEPTH   = 2 ** IROM_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/irom_fetch_fifo.sv
// Synchronous FIFO of {last, pixel} entries sitting between ROM capture and
// the downstream valid/ready handshake.
module irom_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read,
    // so stale entries are never observable and the array maps to plain RAM.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/irom_fetch_ctrl.sv
// Image-ROM read sequencer: windowed wrapping fetch, latency-absorbing FIFO,
// valid/ready pixel stream. Optional chksum output under IROM_FETCH_CHKSUM_EN.
module irom_fetch_ctrl
    import irom_pkg::*;
#(
    parameter int ADDR_W = IROM_ADDR_W,
    parameter int DATA_W = IROM_DATA_W,
    parameter int FIFO_D = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              rom_cen,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] px_data,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              px_last,
`ifdef IROM_FETCH_CHKSUM_EN
    output logic [15:0]       chksum,
`endif
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_D + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rom_a;
    logic [ADDR_W:0]   r_remain;
    logic [ADDR_W-1:0] r_seq;
    logic [ADDR_W-1:0] r_last_idx;
    logic              r_cen;
    logic              r_pend;
    logic              r_done;

    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W:0]   w_head;
    logic              w_inflight;
    logic              w_pop;
    logic              w_start;
    logic              w_issue;
    logic [OCC_W-1:0]  w_occ;

    assign w_inflight = ~r_cen;
    assign w_pop      = px_valid & px_ready;
    assign w_start    = start & (r_state == IDLE);

    // Entries already held, plus the one in ROM, plus the one being read,
    // minus the one leaving this edge: a new read must still find a slot.
    assign w_occ   = OCC_W'(w_count) + OCC_W'(r_pend) + OCC_W'(w_inflight) - OCC_W'(w_pop);
    assign w_issue = (r_state == FETCH) && !w_full && (w_occ <= OCC_W'(FIFO_D - 1));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rom_a    <= '0;
            r_remain   <= '0;
            r_seq      <= '0;
            r_last_idx <= '0;
            r_cen      <= 1'b1;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // NOTE: defaults first so chip enable and done drop back to idle
            // whenever no branch below claims them this cycle.
            r_cen  <= 1'b1;
            r_done <= 1'b0;
            r_pend <= w_inflight;
            if (r_pend) r_seq <= r_seq + ADDR_W'(1);

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_state    <= FETCH;
                            r_addr     <= start_addr;
                            r_remain   <= len;
                            r_last_idx <= len[ADDR_W-1:0] - ADDR_W'(1);
                            r_seq      <= '0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_cen    <= 1'b0;
                        r_rom_a  <= r_addr;
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_remain <= r_remain - (ADDR_W + 1)'(1);
                        if (r_remain == (ADDR_W + 1)'(1)) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head[DATA_W]) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    irom_fetch_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RESET_N),
        .i_push  (r_pend),
        .i_wdata ({(r_seq == r_last_idx), rom_q}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef IROM_FETCH_CHKSUM_EN
    logic [15:0] r_chksum;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)   r_chksum <= '0;
        else if (w_start) r_chksum <= '0;
        else if (w_pop)   r_chksum <= r_chksum + 16'(px_data);
    end

    assign chksum = r_chksum;
`endif

    // Head outputs are masked when empty so reset shows zeros, not old RAM.
    assign px_valid = ~w_empty;
    assign px_data  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign px_last  = ~w_empty & w_head[DATA_W];
    assign rom_cen  = r_cen;
    assign rom_a    = r_rom_a;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_irom_fetch_ctrl.sv
// Scoreboard bench for irom_fetch_ctrl: stimulus queues expected addresses and
// pixels, an independent monitor compares them against every ROM read and beat.
module tb_irom_fetch_ctrl;
    localparam int FIFO_D = 4;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       start;
    logic [5:0] start_addr;
    logic [6:0] len;
    logic       rom_cen;
    logic [5:0] rom_a;
    logic [7:0] rom_q = 8'h00;
    logic [7:0] px_data;
    logic       px_valid;
    logic       px_ready;
    logic       px_last;
    logic       busy;
    logic       done;
`ifdef IROM_FETCH_CHKSUM_EN
    logic [15:0] chksum;
`endif

    logic [7:0] rom_mem [64];
    logic [5:0] exp_a  [$];
    logic [8:0] exp_px [$];

    int total = 0;
    int bad   = 0;
    int beats = 0;

    irom_fetch_ctrl #(.ADDR_W(6), .DATA_W(8), .FIFO_D(FIFO_D)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .rom_cen    (rom_cen),
        .rom_a      (rom_a),
        .rom_q      (rom_q),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_last    (px_last),
`ifdef IROM_FETCH_CHKSUM_EN
        .chksum     (chksum),
`endif
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge CLK) begin
        if (!rom_cen) rom_q <= rom_mem[rom_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Monitor: samples 2 time units before each rising edge.
    logic       prev_hold = 1'b0;
    logic [9:0] prev_word = '0;
    logic       exp_done  = 1'b0;
    logic       hs;
    int         issued = 0;
    int         popped = 0;
    logic [8:0] exp_word;

    always begin
        @(negedge CLK);
        #3;
        if (!RESET_N) begin
            prev_hold = 1'b0;
            exp_done  = 1'b0;
            issued    = 0;
            popped    = 0;
        end else begin
            check("done_pulse", {31'd0, done}, {31'd0, exp_done});
            if (prev_hold)
                check("stall_hold", {22'd0, px_valid, px_last, px_data}, {22'd0, prev_word});
            if (!rom_cen) begin
                issued++;
                total++;
                if (issued - popped > FIFO_D) begin
                    bad++;
                    $display("FAIL occupancy: got %0d limit %0d at %0t", issued - popped, FIFO_D, $time);
                end
                if (exp_a.size() == 0) fail_now("rom_a_extra_read");
                else check("rom_a", {26'd0, rom_a}, {26'd0, exp_a.pop_front()});
            end
            hs = px_valid && px_ready;
            if (hs) begin
                popped++;
                beats++;
                if (exp_px.size() == 0) fail_now("pixel_extra_beat");
                else begin
                    exp_word = exp_px.pop_front();
                    check("pixel", {23'd0, px_last, px_data}, {23'd0, exp_word});
                end
            end
            exp_done  = (hs && px_last) || (start && !busy && (len == 7'd0));
            prev_hold = px_valid && !px_ready;
            prev_word = {px_valid, px_last, px_data};
        end
    end

    task automatic start_window(input int addr, input int n);
        int a;
        @(negedge CLK);
        start      = 1'b1;
        start_addr = 6'(addr);
        len        = 7'(n);
        for (int i = 0; i < n; i++) begin
            a = (addr + i) % 64;
            exp_a.push_back(6'(a));
            exp_px.push_back({(i == n - 1), rom_mem[a]});
        end
    endtask

    // Drives px_ready from a pattern (with a 10-cycle low window) until done.
    task automatic run_until_done(input logic [31:0] pat, input int stall_from,
                                  input int budget, output int cycles);
        cycles = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            start = 1'b0;
            if (done) begin
                cycles = c + 1;
                break;
            end
            px_ready = pat[c % 32] && !(c >= stall_from && c < stall_from + 10);
        end
        px_ready = 1'b1;
        if (cycles < 0) fail_now("done_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_cen"},  {31'd0, rom_cen},  32'd1);
        check({tag, "_rom_a"},    {26'd0, rom_a},    32'd0);
        check({tag, "_px_data"},  {24'd0, px_data},  32'd0);
        check({tag, "_px_valid"}, {31'd0, px_valid}, 32'd0);
        check({tag, "_px_last"},  {31'd0, px_last},  32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
`ifdef IROM_FETCH_CHKSUM_EN
        check({tag, "_chksum"},   {16'd0, chksum},   32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_done;
        int n_cen;
        int n_busy;
        int b0;
        logic reached;

        for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i);
        RESET_N    = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        len        = '0;
        px_ready   = 1'b1;

        repeat (2) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Full image, ready always high: explicit 3-cycle latency, then one beat per cycle.
        start_window(0, 64);
        @(negedge CLK);
        start = 1'b0;
        #1;
        check("t1_busy_after_start", {31'd0, busy},     32'd1);
        check("t1_cen_high_k",       {31'd0, rom_cen},  32'd1);
        @(negedge CLK);
        #1;
        check("t1_cen_low_k1",       {31'd0, rom_cen},  32'd0);
        check("t1_valid_low_k1",     {31'd0, px_valid}, 32'd0);
        @(negedge CLK);
        #1;
        check("t1_valid_low_k2",     {31'd0, px_valid}, 32'd0);
        @(negedge CLK);
        #1;
        check("t1_valid_high_k3",    {31'd0, px_valid}, 32'd1);
        check("t1_first_pixel",      {24'd0, px_data},  32'd0);
        run_until_done(32'hFFFF_FFFF, -100, 200, cyc);
        check("t1_done_cycle", 32'(cyc), 32'd64);
`ifdef IROM_FETCH_CHKSUM_EN
        check("t1_chksum", {16'd0, chksum}, 32'd2016);
`endif
        check("t1_px_left", 32'(exp_px.size()), 32'd0);

        // Wrapping window 62,63,0,1.
        start_window(62, 4);
        run_until_done(32'hFFFF_FFFF, -100, 50, cyc);
        check("t2_done_cycle", 32'(cyc), 32'd8);
        check("t2_px_left", 32'(exp_px.size()), 32'd0);
        check("t2_a_left",  32'(exp_a.size()),  32'd0);

        // Irregular ready with a 10-cycle stall mid-stream.
        start_window(0, 64);
        run_until_done(32'hB6E5_D3B7, 20, 600, cyc);
        check("t3_px_left", 32'(exp_px.size()), 32'd0);
        check("t3_a_left",  32'(exp_a.size()),  32'd0);

        // Zero-length request.
        @(negedge CLK);
        start      = 1'b1;
        start_addr = 6'd7;
        len        = 7'd0;
        n_done = 0;
        n_cen  = 0;
        n_busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            start = 1'b0;
            #1;
            if (done)     n_done++;
            if (!rom_cen) n_cen++;
            if (busy)     n_busy++;
        end
        check("t4_done_pulses", 32'(n_done), 32'd1);
        check("t4_cen_lows",    32'(n_cen),  32'd0);
        check("t4_busy_cycles", 32'(n_busy), 32'd0);

        // Start pulsed while busy is ignored.
        start_window(10, 8);
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        start      = 1'b1;
        start_addr = 6'd40;
        len        = 7'd5;
        @(negedge CLK);
        start = 1'b0;
        run_until_done(32'hFFFF_FFFF, -100, 50, cyc);
        check("t5_done_cycle", 32'(cyc), 32'd8);
        repeat (4) @(negedge CLK);
        check("t5_busy_after", {31'd0, busy}, 32'd0);
        check("t5_px_left", 32'(exp_px.size()), 32'd0);
        check("t5_a_left",  32'(exp_a.size()),  32'd0);

        // Asynchronous reset after 20 beats, then a fresh 2-pixel window.
        b0 = beats;
        start_window(0, 64);
        reached = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            start = 1'b0;
            if (beats - b0 >= 20) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) fail_now("t6_beat_timeout");
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        exp_px.delete();
        exp_a.delete();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i + 100);
        b0 = beats;
        start_window(5, 2);
        run_until_done(32'hFFFF_FFFF, -100, 50, cyc);
        check("t6_done_cycle", 32'(cyc), 32'd6);
        repeat (3) @(negedge CLK);
        check("t6_fresh_beats", 32'(beats - b0), 32'd2);
        check("t6_px_left", 32'(exp_px.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
